// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, synchronous imem read, 2-entry output queue.
// Optional misaligned-redirect fault marker enabled by defining MISALIGN_TRAP_EN.
module mips_fetch_stage #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              out_fault
);

  // Handshake: a beat transfers on a clock edge where out_valid && out_ready;
  // out_valid never drops and out_* never change while a beat waits unaccepted,
  // except on redirect or reset, which discard the waiting beat.

  logic [31:0] pc;
  logic [31:0] tag;
  logic        inflight;
  logic [1:0]  count;
  logic        halted;
  logic        fault_pend;

  logic [31:0] q0_pc, q0_instr, q1_pc, q1_instr;
  logic        q0_fault, q1_fault;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [31:0] redirect_target;
  logic        misaligned;
  logic [31:0] push_pc, push_instr;
  logic        push_fault;

`ifdef MISALIGN_TRAP_EN
  assign redirect_target = redirect_pc;
  assign misaligned      = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign misaligned          = 1'b0;
`endif

  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !reset && !redirect_valid && !halted && (occupancy < 3'd2);
  assign imem_en   = issue;
  assign imem_addr = pc[ADDR_W+1:2];

  // A redirect kills both the in-flight read and a pending fault marker.
  assign push       = (inflight || fault_pend) && !redirect_valid;
  assign push_pc    = tag;
  assign push_instr = fault_pend ? 32'h0 : imem_rdata;
  assign push_fault = fault_pend;

  assign out_valid = (count != 2'd0);
  assign out_pc    = q0_pc;
  assign out_instr = q0_instr;
  assign out_fault = q0_fault;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      tag      <= 32'h0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_target;
      tag      <= redirect_target;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag <= pc;
        pc  <= pc + 32'd4;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted     <= 1'b0;
      fault_pend <= 1'b0;
    end else if (redirect_valid) begin
      halted     <= misaligned;
      fault_pend <= misaligned;
    end else begin
      fault_pend <= 1'b0;
    end
  end
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign halted            = 1'b0;
  assign fault_pend        = 1'b0;
`endif

  // Entry 0 is the head; entry 1 only holds data when count == 2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= 2'd0;
      q0_pc    <= 32'h0;
      q0_instr <= 32'h0;
      q0_fault <= 1'b0;
      q1_pc    <= 32'h0;
      q1_instr <= 32'h0;
      q1_fault <= 1'b0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      if (pop && push) begin
        if (count == 2'd1) begin
          q0_pc    <= push_pc;
          q0_instr <= push_instr;
          q0_fault <= push_fault;
        end else begin
          q0_pc    <= q1_pc;
          q0_instr <= q1_instr;
          q0_fault <= q1_fault;
          q1_pc    <= push_pc;
          q1_instr <= push_instr;
          q1_fault <= push_fault;
        end
      end else if (pop) begin
        q0_pc    <= q1_pc;
        q0_instr <= q1_instr;
        q0_fault <= q1_fault;
        count    <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) begin
          q0_pc    <= push_pc;
          q0_instr <= push_instr;
          q0_fault <= push_fault;
        end else begin
          q1_pc    <= push_pc;
          q1_instr <= push_instr;
          q1_fault <= push_fault;
        end
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: reset, streaming, stall, redirect, wrap,
// mid-stream reset and (with MISALIGN_TRAP_EN) the misaligned-fetch fault marker.
module tb_mips_fetch_stage;

  localparam int ADDR_W = 10;

  logic              clock;
  logic              reset;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              out_fault;

  int tests;
  int fails;

  logic [31:0] mem [1024];

  mips_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous-read instruction memory
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd100 + 32'd3 * i;
    mem[0] = 32'd32;
    mem[1] = 32'd25;
    mem[2] = 32'd7;
    imem_rdata     = 32'h0;
    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();

    // reset state
    check("rst_valid", {31'h0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_fault", {31'h0, out_fault}, 32'd0);
    check("rst_en", {31'h0, imem_en}, 32'd0);

    // 1: reset release and streaming
    reset = 1'b0;
    #1;
    check("t1_en", {31'h0, imem_en}, 32'd1);
    check("t1_addr", {22'h0, imem_addr}, 32'd0);
    tick();
    check("t1_valid_c1", {31'h0, out_valid}, 32'd0);
    tick();
    check("t1_valid_c2", {31'h0, out_valid}, 32'd1);
    check("t1_pc0", out_pc, 32'h0);
    check("t1_in0", out_instr, 32'd32);
    tick();
    check("t1_pc1", out_pc, 32'h4);
    check("t1_in1", out_instr, 32'd25);
    tick();
    check("t1_pc2", out_pc, 32'h8);
    check("t1_in2", out_instr, 32'd7);

    // 2: backpressure
    out_ready = 1'b0;
    #1;
    check("t2_en_drop", {31'h0, imem_en}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", {31'h0, out_valid}, 32'd1);
      check("t2_hold_pc", out_pc, 32'h8);
      check("t2_hold_in", out_instr, 32'd7);
      check("t2_hold_en", {31'h0, imem_en}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("t2_pc12", out_pc, 32'hC);
    check("t2_in12", out_instr, 32'd109);
    tick();
    check("t2_pc16", out_pc, 32'h10);
    check("t2_in16", out_instr, 32'd112);
    tick();
    check("t2_pc20", out_pc, 32'h14);
    check("t2_in20", out_instr, 32'd115);

    // 3: redirect with one queued and one in flight
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check("t3_en_redir", {31'h0, imem_en}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #1;
    check("t3_flushed", {31'h0, out_valid}, 32'd0);
    check("t3_en", {31'h0, imem_en}, 32'd1);
    check("t3_addr", {22'h0, imem_addr}, 32'd16);
    tick();
    check("t3_valid_c1", {31'h0, out_valid}, 32'd0);
    tick();
    check("t3_valid_c2", {31'h0, out_valid}, 32'd1);
    check("t3_pc", out_pc, 32'h40);
    check("t3_in", out_instr, 32'd148);

    // 4: address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_addr_top", {22'h0, imem_addr}, 32'h3FF);
    check("t4_en", {31'h0, imem_en}, 32'd1);
    tick();
    check("t4_addr_wrap", {22'h0, imem_addr}, 32'h0);
    tick();
    check("t4_pc_ffc", out_pc, 32'hFFC);
    check("t4_in_ffc", out_instr, 32'd3169);
    tick();
    check("t4_pc_1000", out_pc, 32'h1000);
    check("t4_in_1000", out_instr, 32'd32);

    // 5: reset with queue full
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("t5_full_valid", {31'h0, out_valid}, 32'd1);
    check("t5_full_en", {31'h0, imem_en}, 32'd0);
    reset = 1'b1;
    #1;
    check("t5_async_valid", {31'h0, out_valid}, 32'd0);
    check("t5_async_pc", out_pc, 32'h0);
    check("t5_async_en", {31'h0, imem_en}, 32'd0);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t5_restart_addr", {22'h0, imem_addr}, 32'd0);
    check("t5_restart_en", {31'h0, imem_en}, 32'd1);
    tick();
    tick();
    check("t5_pc0", out_pc, 32'h0);
    check("t5_in0", out_instr, 32'd32);

    // 6: misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    #1;
`ifdef MISALIGN_TRAP_EN
    check("t6_valid_c1", {31'h0, out_valid}, 32'd0);
    check("t6_en_halt", {31'h0, imem_en}, 32'd0);
    tick();
    check("t6_fault_valid", {31'h0, out_valid}, 32'd1);
    check("t6_fault", {31'h0, out_fault}, 32'd1);
    check("t6_fault_pc", out_pc, 32'h42);
    check("t6_fault_in", out_instr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_halt_valid", {31'h0, out_valid}, 32'd0);
      check("t6_halt_en", {31'h0, imem_en}, 32'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("t6_resume_valid", {31'h0, out_valid}, 32'd1);
    check("t6_resume_pc", out_pc, 32'h80);
    check("t6_resume_in", out_instr, 32'd196);
    check("t6_resume_fault", {31'h0, out_fault}, 32'd0);
`else
    check("t6_forced_addr", {22'h0, imem_addr}, 32'd16);
    tick();
    tick();
    check("t6_forced_valid", {31'h0, out_valid}, 32'd1);
    check("t6_forced_pc", out_pc, 32'h40);
    check("t6_forced_in", out_instr, 32'd148);
    check("t6_forced_fault", {31'h0, out_fault}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the MIPS execute stage.
- Owns the PC, drives a synchronous-read instruction memory, and buffers fetched words in a 2-entry queue.
- Delivers {pc, instr} to execute over a valid/ready handshake, with redirect (branch/jump) and backpressure support.

Parameters:
- ADDR_W, 10, word-address width of instruction memory (depth 2^ADDR_W = 1024 words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_en  out  1  read strobe; read issued this cycle.
- imem_addr  out  ADDR_W  word address = pc[ADDR_W+1:2].
- imem_rdata  in  32  read data, valid exactly 1 cycle after imem_en.
- redirect_valid  in  1  load new PC, flush in-flight and queued words.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  execute accepts head.
- out_instr  out  32  head instruction word.
- out_pc  out  32  byte PC of head instruction.
- out_fault  out  1  head is misaligned-fetch fault marker (0 when feature disabled).

Behaviour:
- Reset values: pc=RESET_PC, queue count=0, inflight=0, halted=0. out_valid=0, out_instr=0, out_pc=0, out_fault=0, imem_en=0.
- Outputs out_* come from queue-head registers only; no combinational path from inputs to out_*.
- Transfer occurs when out_valid && out_ready (pop).
- Issue rule: imem_en=1 iff !reset && !redirect_valid && !halted && (count + inflight - pop) < 2.
  - Queue never overflows.
  - Sustained 1 word/cycle when out_ready is held high.
- On issue:
  - inflight <= 1.
  - Tag register <= pc.
  - pc <= pc + 4, wrapping mod 2^32; imem_addr therefore wraps mod 2^ADDR_W.
- Response: the cycle after issue, if not killed, {tag, imem_rdata} is pushed to the queue tail.
- Queue is 2-entry FIFO with count 0..2.
  - Simultaneous push and pop keeps count unchanged and preserves order.
  - Push into empty queue: word appears on out_* the following cycle.
- Latency: first out_valid 2 cycles after reset deassert (issue at edge 1, push at edge 2).
- Redirect (highest priority):
  - At the clock edge with redirect_valid=1: pc <= redirect_pc; queue count <= 0; any in-flight response is killed (not pushed); no issue that cycle.
  - A handshake completing in the redirect cycle counts as consumed; everything behind it is discarded.
  - Target issued next cycle; out_valid rises 2 cycles after the redirect edge.
  - Back-to-back redirects: the last one wins.
- Stall (out_ready=0 with queue full, count=2): imem_en=0; pc holds; out_* hold stable.
- Reset asserted mid-operation: all state cleared asynchronously; the pending response is dropped.
- redirect_pc[1:0] != 0 without the optional feature: low bits forced to 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Redirect with redirect_pc[1:0] != 0 enqueues a single entry {pc=redirect_pc, instr=0, fault=1} one cycle after the redirect edge.
  - halted is then set; no further issue occurs until the next aligned redirect or reset.
  - A misaligned redirect while halted re-enqueues the fault entry.
- Undefined: low bits forced to 0; out_fault tied to 0; halted is constant 0.

Test Plan:
1. Reset release, imem[0]=32, imem[1]=25, imem[2]=7, out_ready=1 → out_valid at cycle 2; consecutive beats (pc 0, instr 32), (4, 25), (8, 7); one beat per cycle.
2. Hold out_ready=0 from cycle 3 for 5 cycles, then release → queue fills to 2; imem_en=0 while full; out_pc/out_instr stable; after release, no word lost or duplicated (pc sequence contiguous).
3. Redirect to 0x40 while one word is in flight and one is queued → neither is delivered; next out beat has pc 0x40 and instr=imem[16], 2 cycles after the redirect edge.
4. pc=0xFFC with ADDR_W=10 and free-run → next fetch pc=0x1000, imem_addr=0; wrap correct.
5. Assert reset for 1 cycle mid-stream with queue full → out_valid=0 immediately; after release, fetch restarts at RESET_PC.
6. (MISALIGN_TRAP_EN) Redirect to 0x42 → one beat with out_fault=1, out_pc=0x42; then no beats; redirect to 0x80 resumes normal fetch.
